gpio_ports: RTL and testbench

Parametrised multi-port parallel I/O block, the next-generation replacement for the fixed two-port RIOT-style I/O. It provides `NPORTS` bidirectional ports of `WIDTH` bits, each with a data register and a data-direction register, behind the same single-cycle register bus. It also adds 2-flop input synchronisation and an optional per-port edge-detect interrupt on each port's MSB. It sits on the CPU register bus beside the timer and RAM/ROM decoders and drives the pad ring.

---
 rtl/gpio_pkg.sv | 13 +
 rtl/gpio_sync2.sv | 25 ++
 rtl/gpio_ports.sv | 171 +++++++++++++++++
 tb/tb_gpio_ports.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - shared address map, limits and types for the gpio_ports block.
package gpio_pkg;

  typedef logic [3:0] gpio_addr_t;

  localparam int         GPIO_NPORTS_MAX = 4;
  localparam int         GPIO_WIDTH_MAX  = 8;

  localparam gpio_addr_t GPIO_A_IER = 4'd8;
  localparam gpio_addr_t GPIO_A_POL = 4'd9;
  localparam gpio_addr_t GPIO_A_IFR = 4'd10;

endpackage

// File: rtl/gpio_sync2.sv
// rtl/gpio_sync2.sv - parametrised-width two-flop synchroniser, sync active-high reset to 0.
module gpio_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1_q, s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/gpio_ports.sv
// rtl/gpio_ports.sv - NPORTS x WIDTH bidirectional ports with data/DDR registers and registered reads.
// Define GPIO_EDGE_IRQ_EN to add per-port MSB edge flags, IER/polarity/IFR registers and irq.
module gpio_ports
  import gpio_pkg::*;
#(
  parameter int NPORTS = 2,
  parameter int WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    we_n,
  input  gpio_addr_t              A,
  input  logic [WIDTH-1:0]        DI,
  output logic [WIDTH-1:0]        DO,
  output logic                    OE,
  input  logic [NPORTS*WIDTH-1:0] PI,
  output logic [NPORTS*WIDTH-1:0] PO,
  output logic [NPORTS*WIDTH-1:0] POE,
  output logic                    irq
);

  localparam int NW     = NPORTS * WIDTH;
  localparam int PSEL_W = $clog2(GPIO_NPORTS_MAX);

  logic              rd_req, wr_req;
  logic              port_hit, is_ddr;
  logic [PSEL_W-1:0] port_sel;
  logic [NW-1:0]     pi_s, merged;
  logic [NW-1:0]     po_q, po_d, poe_q, poe_d;
  logic [WIDTH-1:0]  port_rdata, irq_rdata;
  logic [WIDTH-1:0]  do_q, do_d;
  logic              oe_q, oe_d;

  assign rd_req   = enable & we_n;
  assign wr_req   = enable & ~we_n;
  assign port_sel = A[PSEL_W:1];
  assign is_ddr   = A[0];
  assign port_hit = ~A[3] && (int'(port_sel) < NPORTS);

  gpio_sync2 #(.W(NW)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (PI),
    .q   (pi_s)
  );

  // Output pins read back their own register; input pins read the synchronised pad.
  assign merged = (po_q & poe_q) | (pi_s & ~poe_q);

  always_comb begin
    po_d       = po_q;
    poe_d      = poe_q;
    port_rdata = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (port_hit && (port_sel == PSEL_W'(p))) begin
        port_rdata = is_ddr ? poe_q[p*WIDTH +: WIDTH] : merged[p*WIDTH +: WIDTH];
        if (wr_req) begin
          if (is_ddr) begin
            poe_d[p*WIDTH +: WIDTH] = DI;
          end else begin
            po_d[p*WIDTH +: WIDTH] = DI;
          end
        end
      end
    end
  end

`ifdef GPIO_EDGE_IRQ_EN
  logic [NPORTS-1:0] ier_q, ier_d;
  logic [NPORTS-1:0] pol_q, pol_d;
  logic [NPORTS-1:0] ifr_q, ifr_d;
  logic [NPORTS-1:0] prev_q, cur_msb, edge_hit, di_mask;
  logic              irq_q;

  function automatic logic [WIDTH-1:0] widen(input logic [NPORTS-1:0] v);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int b = 0; b < WIDTH; b++) begin
      if (b < NPORTS) r[b] = v[b % NPORTS];
    end
    return r;
  endfunction

  always_comb begin
    cur_msb = '0;
    di_mask = '0;
    for (int p = 0; p < NPORTS; p++) begin
      cur_msb[p] = pi_s[p*WIDTH + WIDTH - 1];
      di_mask[p] = (p < WIDTH) ? DI[p % WIDTH] : 1'b0;
    end
  end

  assign edge_hit = (pol_q & cur_msb & ~prev_q) | (~pol_q & ~cur_msb & prev_q);

  always_comb begin
    ier_d     = ier_q;
    pol_d     = pol_q;
    ifr_d     = ifr_q;
    irq_rdata = '0;
    case (A)
      GPIO_A_IER: begin
        irq_rdata = widen(ier_q);
        if (wr_req) ier_d = di_mask;
      end
      GPIO_A_POL: begin
        irq_rdata = widen(pol_q);
        if (wr_req) pol_d = di_mask;
      end
      GPIO_A_IFR: begin
        irq_rdata = widen(ifr_q);
        if (rd_req) ifr_d = '0;
        if (wr_req) ifr_d = ifr_q & ~di_mask;
      end
      default: ;
    endcase
    // A fresh edge beats a clear landing in the same cycle.
    ifr_d = ifr_d | edge_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ier_q  <= '0;
      pol_q  <= '0;
      ifr_q  <= '0;
      prev_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      ier_q  <= ier_d;
      pol_q  <= pol_d;
      ifr_q  <= ifr_d;
      prev_q <= cur_msb;
      irq_q  <= |(ifr_q & ier_q);
    end
  end

  assign irq = irq_q;
`else
  assign irq_rdata = '0;
  assign irq       = 1'b0;
`endif

  always_comb begin
    do_d = do_q;
    oe_d = 1'b0;
    if (rd_req) begin
      oe_d = 1'b1;
      do_d = port_hit ? port_rdata : irq_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      po_q  <= '0;
      poe_q <= '0;
      do_q  <= '0;
      oe_q  <= 1'b0;
    end else begin
      po_q  <= po_d;
      poe_q <= poe_d;
      do_q  <= do_d;
      oe_q  <= oe_d;
    end
  end

  assign PO  = po_q;
  assign POE = poe_q;
  assign DO  = do_q;
  assign OE  = oe_q;

endmodule

// File: tb/tb_gpio_ports.sv
// tb/tb_gpio_ports.sv - self-checking bench for gpio_ports (3 ports x 8 bits), either GPIO_EDGE_IRQ_EN build.
module tb_gpio_ports;

  localparam int NP = 3;
  localparam int W  = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            enable;
  logic            we_n;
  logic [3:0]      A;
  logic [W-1:0]    DI;
  logic [W-1:0]    DO;
  logic            OE;
  logic [NP*W-1:0] PI;
  logic [NP*W-1:0] PO;
  logic [NP*W-1:0] POE;
  logic            irq;

  gpio_ports #(.NPORTS(NP), .WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .we_n   (we_n),
    .A      (A),
    .DI     (DI),
    .DO     (DO),
    .OE     (OE),
    .PI     (PI),
    .PO     (PO),
    .POE    (POE),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: registers as plain arrays, pad history as the last three sampled PI words.
  logic [NP*W-1:0] m_po, m_ddr;
  logic [NP-1:0]   m_ier, m_pol, m_ifr;
  logic [W-1:0]    m_do;
  logic            m_oe, m_irq;
  logic [NP*W-1:0] pin_hist [3];
  bit              started = 0;

  function automatic logic [W-1:0] model_read(input logic [3:0] a);
    int p;
    logic [W-1:0] pad;
    if (int'(a) < 2 * NP) begin
      p   = int'(a) / 2;
      pad = pin_hist[1][p*W +: W];
      if (a[0]) return m_ddr[p*W +: W];
      return (m_po[p*W +: W] & m_ddr[p*W +: W]) | (pad & ~m_ddr[p*W +: W]);
    end
`ifdef GPIO_EDGE_IRQ_EN
    if (a == 4'd8)  return W'(m_ier);
    if (a == 4'd9)  return W'(m_pol);
    if (a == 4'd10) return W'(m_ifr);
`endif
    return '0;
  endfunction

  always @(posedge clk) begin : model
    logic [W-1:0]  rd;
    logic [NP-1:0] new_flags;
    started = 1;
    if (rst) begin
      m_po = '0; m_ddr = '0; m_ier = '0; m_pol = '0; m_ifr = '0;
      m_do = '0; m_oe = 1'b0; m_irq = 1'b0;
      for (int h = 0; h < 3; h++) pin_hist[h] = '0;
    end else begin
      rd        = model_read(A);
      new_flags = '0;
`ifdef GPIO_EDGE_IRQ_EN
      m_irq = |(m_ifr & m_ier);
      for (int p = 0; p < NP; p++) begin
        logic now_b, was_b;
        now_b = pin_hist[1][p*W + W - 1];
        was_b = pin_hist[2][p*W + W - 1];
        if (m_pol[p] ? (now_b && !was_b) : (was_b && !now_b)) new_flags[p] = 1'b1;
      end
`endif
      m_oe = enable && we_n;
      if (enable && we_n) m_do = rd;
      if (enable && !we_n) begin
        if (int'(A) < 2 * NP) begin
          if (A[0]) m_ddr[(int'(A)/2)*W +: W] = DI;
          else      m_po[(int'(A)/2)*W +: W]  = DI;
        end
`ifdef GPIO_EDGE_IRQ_EN
        if (A == 4'd8)  m_ier = DI[NP-1:0];
        if (A == 4'd9)  m_pol = DI[NP-1:0];
        if (A == 4'd10) m_ifr = m_ifr & ~DI[NP-1:0];
`endif
      end
`ifdef GPIO_EDGE_IRQ_EN
      if (enable && we_n && A == 4'd10) m_ifr = '0;
      m_ifr = m_ifr | new_flags;
`endif
      pin_hist[2] = pin_hist[1];
      pin_hist[1] = pin_hist[0];
      pin_hist[0] = PI;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("DO",  DO,  m_do);
      check("OE",  OE,  m_oe);
      check("PO",  PO,  m_po);
      check("POE", POE, m_ddr);
      check("irq", irq, m_irq);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    enable = 1'b0;
    we_n   = 1'b1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    enable = 1'b1; we_n = 1'b0; A = a; DI = d;
    step();
    idle();
  endtask

  task automatic rd(input logic [3:0] a);
    enable = 1'b1; we_n = 1'b1; A = a;
    step();
    idle();
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; we_n = 1'b1; A = '0; DI = '0; PI = '0;
    step(2);
    rst = 1'b0;
    check("reset_PO", PO, 0);
    check("reset_POE", POE, 0);
    check("reset_DO", DO, 0);
    check("reset_OE", OE, 0);
    check("reset_irq", irq, 0);

    for (int a = 0; a < 16; a++) begin
      enable = 1'b1; we_n = 1'b1; A = 4'(a);
      step();
      check("sweep_DO", DO, 0);
      check("sweep_OE", OE, 1);
    end
    idle();
    step();
    check("sweep_OE_idle", OE, 0);

    wr(4'd1, 8'hFF); wr(4'd0, 8'h81);
    wr(4'd3, 8'hF0); wr(4'd2, 8'hA5);
    wr(4'd5, 8'h00); wr(4'd4, 8'h77);
    PI = 24'h5A3C0F;
    step(2);
    rd(4'd2); check("port1_merged", DO, 8'hAC);
    rd(4'd0); check("port0_out", DO, 8'h81);
    rd(4'd4); check("port2_in", DO, 8'h5A);
    rd(4'd3); check("port1_ddr", DO, 8'hF0);
    check("POE_port1", POE[15:8], 8'hF0);
    check("PO_port1", PO[15:8], 8'hA5);
    wr(4'd6, 8'hFF); wr(4'd7, 8'hFF);
    check("unmapped_wr_PO", PO, 24'h77A581);
    check("unmapped_wr_POE", POE, 24'h00F0FF);
    rd(4'd6); check("rd_A6", DO, 0);
    rd(4'd7); check("rd_A7", DO, 0);

`ifdef GPIO_EDGE_IRQ_EN
    wr(4'd9, 8'h01); wr(4'd8, 8'h01);
    rd(4'd9); check("pol_rb", DO, 8'h01);
    PI[7] = 1'b1;
    step(3); check("rise_irq_e3", irq, 0);
    step(1); check("rise_irq_e4", irq, 1);
    rd(4'd10); check("ifr_rise", DO, 8'h01);
    step(1); check("irq_after_clr", irq, 0);

    PI[15] = 1'b1; step(4);
    PI[15] = 1'b0; step(4);
    check("fall_irq_masked", irq, 0);
    rd(4'd10); check("ifr_fall", DO, 8'h02);
    PI[15] = 1'b1; step(4);
    PI[15] = 1'b0; step(4);
    wr(4'd10, 8'h02);
    rd(4'd10); check("ifr_w1c", DO, 8'h00);

    PI[7] = 1'b0; step(4);
    PI[7] = 1'b1; step(2);
    rd(4'd10); check("ifr_race_old", DO, 8'h00);
    step(1);
    rd(4'd10); check("ifr_race_kept", DO, 8'h01);

    wr(4'd9, 8'h00); step(4);
    rd(4'd10); check("pol_wr_no_edge", DO, 8'h00);
    PI[7] = 1'b0; step(4);
    rd(4'd10); check("pol_fall", DO, 8'h01);
`else
    rd(4'd8);  check("rd_A8", DO, 0);
    rd(4'd9);  check("rd_A9", DO, 0);
    rd(4'd10); check("rd_A10", DO, 0);
    for (int t = 0; t < 4; t++) begin
      PI[7] = ~PI[7];
      step(5);
      check("no_irq", irq, 0);
    end
`endif

    enable = 1'b1; we_n = 1'b1; A = 4'd2; rst = 1'b1;
    step();
    rst = 1'b0; idle();
    check("midrst_OE", OE, 0);
    check("midrst_DO", DO, 0);
    check("midrst_PO", PO, 0);
    check("midrst_POE", POE, 0);
    step(2);
    rd(4'd4); check("post_rst_port2", DO, 8'h5A);
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
